// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, writeback requester indices and arbiter defaults.
// Also holds the saturating counter helper used by the writeback arbiter.
package cpu_pkg;

    localparam int XLEN               = 32;
    localparam int AW                 = 5;

    localparam int WB_ALU             = 0;
    localparam int WB_LSU             = 1;
    localparam int WB_MDU             = 2;

    localparam int STARVE_MAX_DEFAULT = 7;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic one-hot rotating-priority arbiter with its own pointer register.
// Defining RF_WB_FIXED_PRIO_EN removes the pointer and gives index 0 fixed top priority.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);

`ifdef RF_WB_FIXED_PRIO_EN

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

`else

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    // Search begins at ptr and wraps; the first valid requester found wins.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                ptr_next = PW'((i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: round-robin grant, registered write stage, x0 filter, starvation flags.
// Build with RF_WB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module rf_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = cpu_pkg::XLEN,
    parameter int AW         = cpu_pkg::AW,
    parameter int STARVE_MAX = cpu_pkg::STARVE_MAX_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [XLEN-1:0]         wr_data,
    output logic                    pend_addr_vld,
    output logic [NUM_REQ-1:0]      starve
);
    import cpu_pkg::*;

    logic [AW-1:0]   gnt_addr;
    logic [XLEN-1:0] gnt_data;
    logic            xfer;
    logic [7:0]      wait_cnt [NUM_REQ];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (req_ready)
    );

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_addr = gnt_addr | req_addr[i*AW +: AW];
                gnt_data = gnt_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign xfer = |req_ready;

    // Writes to x0 still complete the handshake and occupy the stage, but never enable the RF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en         <= 1'b0;
            pend_addr_vld <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            pend_addr_vld <= xfer;
            wr_en         <= xfer && (gnt_addr != '0);
            if (xfer) begin
                wr_addr <= gnt_addr;
                wr_data <= gnt_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i]) begin
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
                end else begin
                    wait_cnt[i] <= 8'd0;
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve[i] = (wait_cnt[i] >= 8'(STARVE_MAX));
        end
    end

endmodule
